// File: rtl/apb_coeff_loader.sv
// Purpose : streams coefficients into one APB completer as consecutive writes, optionally reading each back to verify it.
// Latency : XFER_CYC+1 cycles per word without verify, XFER_CYC+RD_LAT+2 with verify; DONE pulses one cycle after the last word.
// Backpress: CF_RDY is high only while waiting for a word; stream gaps park the sequencer with the M* request fields held.
module apb_coeff_loader #(
    parameter int ADDR_WIDTH  = 7,
    parameter int PDATA_WIDTH = 32,
    parameter int COEFF_WIDTH = 20,
    parameter int COMP        = 4,
    parameter int XFER_CYC    = 3,   // must be >= 2
    parameter int RD_LAT      = 3    // must be >= 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   START,
    input  logic                   VERIFY,
    input  logic [COMP-1:0]        SEL,
    input  logic [ADDR_WIDTH-1:0]  BASE_ADDR,
    input  logic [ADDR_WIDTH-1:0]  LEN,
    input  logic                   CF_VLD,
    input  logic [COEFF_WIDTH-1:0] CF_DATA,
    output logic                   CF_RDY,
    output logic                   MTRANS,
    output logic                   MWRITE,
    output logic [COMP-1:0]        MSELx,
    output logic [ADDR_WIDTH-1:0]  MADDR,
    output logic [COEFF_WIDTH-1:0] MWDATA,
    input  logic [PDATA_WIDTH-1:0] MRDATA,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR,
    output logic [ADDR_WIDTH-1:0]  ERR_ADDR
);

    // Sequencer states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WR      = 3'd2;
    localparam logic [2:0] S_WR_HOLD = 3'd3;
    localparam logic [2:0] S_RD      = 3'd4;
    localparam logic [2:0] S_RD_WAIT = 3'd5;
    localparam logic [2:0] S_CHECK   = 3'd6;
    localparam logic [2:0] S_FIN     = 3'd7;

    // The hold counter counts down to zero; loading N-2 yields N-1 hold cycles.
    localparam int                HOLD_W       = 8;
    localparam logic [HOLD_W-1:0] WR_HOLD_LAST = HOLD_W'(XFER_CYC - 2);
    localparam logic [HOLD_W-1:0] RD_WAIT_LAST = HOLD_W'(RD_LAT - 2);
    localparam logic [HOLD_W-1:0] HOLD_ONE     = HOLD_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [2:0]             state_q,    state_d;
    logic                   verify_q,   verify_d;
    logic [COMP-1:0]        sel_q,      sel_d;
    logic [ADDR_WIDTH-1:0]  len_q,      len_d;
    logic [ADDR_WIDTH-1:0]  addr_q,     addr_d;
    logic [ADDR_WIDTH-1:0]  cnt_q,      cnt_d;
    logic [COEFF_WIDTH-1:0] data_q,     data_d;
    logic                   mwrite_q,   mwrite_d;
    logic [HOLD_W-1:0]      hold_q,     hold_d;
    logic                   err_q,      err_d;
    logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;

    logic                   cf_rdy;
    logic                   advance;
    logic                   m_active;
    logic [COEFF_WIDTH-1:0] rd_word;

    // Only the coefficient-width slice of the read data takes part in the compare.
    assign rd_word = MRDATA[COEFF_WIDTH-1:0];

    generate
        if (PDATA_WIDTH > COEFF_WIDTH) begin : g_rdata_hi
            logic unused_rdata_hi;
            assign unused_rdata_hi = ^MRDATA[PDATA_WIDTH-1:COEFF_WIDTH];
        end
    endgenerate

    assign cf_rdy = (state_q == S_FETCH);

    // Next-state and datapath updates; the advance step is shared by WR_HOLD and CHECK
    always_comb begin
        state_d    = state_q;
        verify_d   = verify_q;
        sel_d      = sel_q;
        len_d      = len_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        mwrite_d   = mwrite_q;
        hold_d     = hold_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        advance    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    verify_d   = VERIFY;
                    sel_d      = SEL;
                    len_d      = LEN;
                    addr_d     = BASE_ADDR;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (CF_VLD && cf_rdy) begin
                    data_d   = CF_DATA;
                    mwrite_d = 1'b1;
                    state_d  = S_WR;
                end
            end
            S_WR: begin
                hold_d  = WR_HOLD_LAST;
                state_d = S_WR_HOLD;
            end
            S_WR_HOLD: begin
                if (hold_q == '0) begin
                    if (verify_q) begin
                        mwrite_d = 1'b0;
                        state_d  = S_RD;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end
            S_RD: begin
                hold_d  = RD_WAIT_LAST;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (hold_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end
            S_CHECK: begin
                // Only the first mismatch of a sequence is recorded.
                if ((rd_word != data_q) && !err_q) begin
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                end
                advance = 1'b1;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (cnt_q == len_q) begin
                state_d = S_FIN;
            end else begin
                addr_d  = addr_q + ADDR_ONE;
                cnt_d   = cnt_q + ADDR_ONE;
                state_d = S_FETCH;
            end
        end
    end

    // State and datapath registers; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            verify_q   <= 1'b0;
            sel_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            mwrite_q   <= 1'b0;
            hold_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            verify_q   <= verify_d;
            sel_q      <= sel_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            mwrite_q   <= mwrite_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // The completer is selected only while a transfer is being requested or held.
    assign m_active = (state_q == S_WR) || (state_q == S_WR_HOLD) ||
                      (state_q == S_RD) || (state_q == S_RD_WAIT);

    assign CF_RDY   = cf_rdy;
    assign MTRANS   = (state_q == S_WR) || (state_q == S_RD);
    assign MWRITE   = mwrite_q;
    assign MSELx    = m_active ? sel_q : '0;
    assign MADDR    = addr_q;
    assign MWDATA   = data_q;
    assign BUSY     = (state_q != S_IDLE) && (state_q != S_FIN);
    assign DONE     = (state_q == S_FIN);
    assign ERR      = err_q;
    assign ERR_ADDR = err_addr_q;

endmodule
